// File: rtl/pipelined_rca_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pipelined_rca_addsub_pkg
//  Brief   : Shared helpers for the pipelined ripple-carry adder/subtractor.
//  Revision: 1.0  initial release
// ============================================================================
package pipelined_rca_addsub_pkg;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb
    );
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_rca_addsub_rca_chunk.sv
`default_nettype none
// ============================================================================
//  Module  : rca_chunk
//  Brief   : Combinational CHUNK-bit ripple-carry adder segment.
//  Revision: 1.0  initial release
// ============================================================================
module rca_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = carry[CHUNK];

endmodule
`default_nettype wire

// File: rtl/pipelined_rca_addsub.sv
`default_nettype none
// ============================================================================
//  Module  : pipelined_rca_addsub
//  Brief   : WIDTH-bit add/sub split into STAGES registered ripple segments,
//            valid/ready on both sides, one beat per clock when not stalled.
//  Revision: 1.0  initial release
// ============================================================================
module pipelined_rca_addsub
    import pipelined_rca_addsub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_rca_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage inputs: the accumulator word carries finished result chunks
    // in its low bits and still-pending operand A bits above them.
    logic [WIDTH-1:0] stg_acc    [STAGES];
    logic [WIDTH-1:0] stg_b      [STAGES];
    logic             stg_cin    [STAGES];
    logic             stg_vld    [STAGES];
    logic [CHUNK-1:0] chunk_sum  [STAGES];
    logic             chunk_cout [STAGES];

    logic [WIDTH-1:0] acc_d   [STAGES];
    logic [WIDTH-1:0] acc_q   [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic             carry_d [STAGES];
    logic             carry_q [STAGES];
    logic             valid_d [STAGES];
    logic             valid_q [STAGES];
    logic             overflow_d;
    logic             overflow_q;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ^ c_in;
    assign en      = !valid_q[STAGES-1] || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stg_acc[k] = a;
            assign stg_b[k]   = b_eff;
            assign stg_cin[k] = cin_eff;
            assign stg_vld[k] = in_valid;
        end else begin : g_link
            assign stg_acc[k] = acc_q[k-1];
            assign stg_b[k]   = b_q[k-1];
            assign stg_cin[k] = carry_q[k-1];
            assign stg_vld[k] = valid_q[k-1];
        end

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a     (stg_acc[k][k*CHUNK +: CHUNK]),
            .b     (stg_b[k][k*CHUNK +: CHUNK]),
            .c_in  (stg_cin[k]),
            .sum   (chunk_sum[k]),
            .c_out (chunk_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            acc_d[k]   = acc_q[k];
            b_d[k]     = b_q[k];
            carry_d[k] = carry_q[k];
            valid_d[k] = valid_q[k];
            if (en) begin
                acc_d[k]                  = stg_acc[k];
                acc_d[k][k*CHUNK +: CHUNK] = chunk_sum[k];
                b_d[k]                    = stg_b[k];
                carry_d[k]                = chunk_cout[k];
                valid_d[k]                = stg_vld[k];
            end
        end

        // The last stage still sees the original A/B MSBs, since its chunk holds them.
        overflow_d = overflow_q;
        if (en) begin
            overflow_d = signed_overflow(stg_acc[STAGES-1][WIDTH-1],
                                         stg_b[STAGES-1][WIDTH-1],
                                         chunk_sum[STAGES-1][CHUNK-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k]   <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k]   <= acc_d[k];
                b_q[k]     <= b_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = acc_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];
    assign overflow  = overflow_q;

endmodule
`default_nettype wire
